// File: rtl/approx_stats_pkg.sv
// Shared types, constants and helpers for the approximate-adder error monitor.
package approx_stats_pkg;

   // Run-control states of the accumulator.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Default adder operand width and the matching {cout, sum} result width.
   localparam int ADDER_W = 16;
   localparam int RES_W   = ADDER_W + 1;

   // Working width of the saturating adder; every accumulator (including the
   // 2*ACC_W squared-error sum) must fit inside it, so ACC_W is capped at 64.
   localparam int SAT_W = 128;

   // Unsigned add that clamps to the all-ones value of a w-bit accumulator.
   // Operands are zero-extended into SAT_W bits by the caller; b may exceed
   // the w-bit limit, in which case the result is clamped as well.
   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input int unsigned      w);
      logic [SAT_W:0]   sum_s;
      logic [SAT_W-1:0] lim_s;
      sum_s = {1'b0, a} + {1'b0, b};
      lim_s = {SAT_W{1'b1}} >> (SAT_W - int'(w));
      if (sum_s > {1'b0, lim_s}) begin
         sat_add = lim_s;
      end else begin
         sat_add = sum_s[SAT_W-1:0];
      end
   endfunction

endpackage

// File: rtl/approx_error_accumulator_abs_diff.sv
// Unsigned error distance |a - b| between the exact and approximate results,
// plus a flag telling whether the two results differ at all.
module abs_diff
   import approx_stats_pkg::*;
#(
   parameter int W = RES_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] ed,
   output logic         nz
);

   // Subtract the smaller from the larger so the result is never negative.
   always_comb begin
      ed = {W{1'b0}};
      if (a >= b) begin
         ed = a - b;
      end else begin
         ed = b - a;
      end
      nz = (ed != {W{1'b0}});
   end

endmodule

// File: rtl/approx_error_accumulator.sv
// Approximate-adder quality monitor: accumulates error-distance statistics
// over a window of WINDOW accepted samples, then pulses done for one cycle.
// Optional build macro APPROX_ERR_SQ_EN adds the ed_sq_sum output (sum of
// squared error distances, for MSE); without it the port and squarer are absent.
module approx_error_accumulator
   import approx_stats_pkg::*;
#(
   parameter int WIDTH  = ADDER_W,
   parameter int WINDOW = 1024,
   parameter int ACC_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH:0]     exact_sum,
   input  logic [WIDTH:0]     approx_sum,
   output logic               busy,
   output logic               done,
   output logic [ACC_W-1:0]   sample_count,
   output logic [ACC_W-1:0]   err_count,
   output logic [ACC_W-1:0]   ed_sum,
   output logic [WIDTH:0]     ed_max
`ifdef APPROX_ERR_SQ_EN
   ,
   output logic [2*ACC_W-1:0] ed_sq_sum
`endif
);

   localparam int RES_LEN = WIDTH + 1;

   state_t               state_r;
   state_t               state_next;
   logic                 in_ready_r;
   logic                 busy_r;
   logic                 done_r;
   logic [ACC_W-1:0]     sample_count_r;
   logic [ACC_W-1:0]     err_count_r;
   logic [ACC_W-1:0]     ed_sum_r;
   logic [RES_LEN-1:0]   ed_max_r;
   logic [RES_LEN-1:0]   ed_s;
   logic                 nz_s;
   logic                 accept_s;
   logic                 last_s;
   logic                 clear_s;

   abs_diff #(
      .W (RES_LEN)
   ) u_abs_diff (
      .a  (exact_sum),
      .b  (approx_sum),
      .ed (ed_s),
      .nz (nz_s)
   );

   // in_ready_r mirrors the ACCUM state, so it doubles as the accept gate.
   assign accept_s = in_valid && in_ready_r;
   assign last_s   = (sample_count_r == ACC_W'(WINDOW - 1));
   assign clear_s  = (state_r == IDLE) && start;

   // Run-control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // Next-state logic: start only counts in IDLE, DONE lasts one cycle.
   always_comb begin
      state_next = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next = ACCUM;
            end else begin
               state_next = IDLE;
            end
         end
         ACCUM: begin
            if (accept_s && last_s) begin
               state_next = DONE;
            end else begin
               state_next = ACCUM;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Status outputs registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         in_ready_r <= (state_next == ACCUM);
         busy_r     <= (state_next == ACCUM);
         done_r     <= (state_next == DONE);
      end
   end

   // Window statistics: cleared on a honoured start, updated per accepted sample.
   always_ff @(posedge clk) begin
      if (rst || clear_s) begin
         sample_count_r <= {ACC_W{1'b0}};
         err_count_r    <= {ACC_W{1'b0}};
         ed_sum_r       <= {ACC_W{1'b0}};
         ed_max_r       <= {RES_LEN{1'b0}};
      end else if (accept_s) begin
         sample_count_r <= sample_count_r + ACC_W'(1);
         err_count_r    <= err_count_r + ACC_W'(nz_s);
         ed_sum_r       <= ACC_W'(sat_add(SAT_W'(ed_sum_r), SAT_W'(ed_s), ACC_W));
         ed_max_r       <= (ed_s > ed_max_r) ? ed_s : ed_max_r;
      end else begin
         sample_count_r <= sample_count_r;
         err_count_r    <= err_count_r;
         ed_sum_r       <= ed_sum_r;
         ed_max_r       <= ed_max_r;
      end
   end

`ifdef APPROX_ERR_SQ_EN
   logic [2*ACC_W-1:0] ed_sq_sum_r;
   logic [SAT_W-1:0]   ed_sq_s;

   // Square of the same error distance, registered alongside the other stats.
   always_comb begin
      ed_sq_s = SAT_W'(ed_s) * SAT_W'(ed_s);
   end

   // Saturating squared-error accumulator for MSE.
   always_ff @(posedge clk) begin
      if (rst || clear_s) begin
         ed_sq_sum_r <= {(2*ACC_W){1'b0}};
      end else if (accept_s) begin
         ed_sq_sum_r <= (2*ACC_W)'(sat_add(SAT_W'(ed_sq_sum_r), ed_sq_s, 2*ACC_W));
      end else begin
         ed_sq_sum_r <= ed_sq_sum_r;
      end
   end

   assign ed_sq_sum = ed_sq_sum_r;
`else
   // Squared-error statistics are not built in this configuration.
`endif

   assign in_ready     = in_ready_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign sample_count = sample_count_r;
   assign err_count    = err_count_r;
   assign ed_sum       = ed_sum_r;
   assign ed_max       = ed_max_r;

endmodule
